masked_write_sequencer: RTL and testbench

Command-driven address sweeper that sits directly upstream of the 8-entry x 32-bit read-modify-write memory. The memory clears bits 31:16 of the addressed word on every enabled cycle. This block accepts one sweep command at a time through a valid/ready handshake and drives the memory's enable and address one word per cycle, wrapping modulo the depth. It also folds the memory's combinational read data into an XOR checksum, reported with a one-cycle done pulse.

---
 rtl/masked_write_sequencer.sv | 112 +++++++++++
 tb/tb_masked_write_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_write_sequencer.sv
// masked_write_sequencer
// Sweeps a contiguous, wrapping range of memory addresses one word per cycle
// on command, driving the memory's enable/address and folding the memory's
// combinational read data into an XOR checksum reported with a done pulse.
`timescale 1ns/1ps

module masked_write_sequencer #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_cmd_valid,
   output logic              io_cmd_ready,
   input  logic [ADDR_W-1:0] io_cmd_base,
   input  logic [CNT_W-1:0]  io_cmd_count,
   input  logic [DATA_W-1:0] io_rd_data,
   output logic              io_enable,
   output logic [ADDR_W-1:0] io_addr,
   output logic              io_busy,
   output logic              io_done,
   output logic [DATA_W-1:0] io_xor
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [CNT_W-1:0]  r_remaining;
   logic [DATA_W-1:0] r_xor_acc;

   state_t            w_state_nxt;
   logic [PW-1:0]     w_ptr_nxt;
   logic [CNT_W-1:0]  w_remaining_nxt;
   logic [DATA_W-1:0] w_xor_nxt;
   logic [CNT_W-1:0]  w_count_clamped;

   // Only the low PW bits of the base select a word; the rest are don't-care.
   logic w_unused_base;
   assign w_unused_base = &{1'b0, io_cmd_base[ADDR_W-1:PW]};

   // Requests longer than the memory would revisit words, so cap at DEPTH.
   assign w_count_clamped = (io_cmd_count > DEPTH_CNT) ? DEPTH_CNT : io_cmd_count;

   // Next-state and next-datapath decode for the sweep FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_remaining_nxt = r_remaining;
      w_xor_nxt       = r_xor_acc;
      case (r_state)
         S_IDLE: begin
            if (io_cmd_valid) begin
               w_xor_nxt       = '0;
               w_ptr_nxt       = io_cmd_base[PW-1:0];
               w_remaining_nxt = w_count_clamped;
               w_state_nxt     = (w_count_clamped == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Read data at this edge is the pre-write value of the word being masked.
            w_xor_nxt       = r_xor_acc ^ io_rd_data;
            w_ptr_nxt       = r_ptr + PW'(1);
            w_remaining_nxt = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over any accept or sweep step.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_xor_acc   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_remaining <= w_remaining_nxt;
         r_xor_acc   <= w_xor_nxt;
      end
   end

   // Outputs decode from registers only.
   assign io_cmd_ready = (r_state == S_IDLE);
   assign io_enable    = (r_state == S_RUN);
   assign io_busy      = (r_state == S_RUN);
   assign io_done      = (r_state == S_DONE);
   assign io_addr      = ADDR_W'(r_ptr);
   assign io_xor       = r_xor_acc;

endmodule

// File: tb/tb_masked_write_sequencer.sv
// Self-checking bench for masked_write_sequencer: an 8x32 masking memory model
// sits downstream, and expected addresses, checksums and memory contents are
// computed from the command (base, clamped count) with plain arithmetic.
`timescale 1ns/1ps

module tb_masked_write_sequencer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_base;
   logic [3:0]  cmd_count;
   logic [31:0] rd_data;
   logic        enable;
   logic [31:0] addr;
   logic        busy;
   logic        done;
   logic [31:0] xor_out;

   logic [31:0] mem       [DEPTH];
   logic [31:0] load_img  [DEPTH];
   logic [31:0] model_mem [DEPTH];
   logic        mem_load;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] exp_last_xor;

   masked_write_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .io_cmd_valid (cmd_valid),
      .io_cmd_ready (cmd_ready),
      .io_cmd_base  (cmd_base),
      .io_cmd_count (cmd_count),
      .io_rd_data   (rd_data),
      .io_enable    (enable),
      .io_addr      (addr),
      .io_busy      (busy),
      .io_done      (done),
      .io_xor       (xor_out)
   );

   always #5 clk = ~clk;

   // Downstream memory: combinational read, clears bits 31:16 on enabled edges.
   assign rd_data = mem[addr[2:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_load) begin
         mem <= load_img;
      end else if (enable) begin
         mem[addr[2:0]] <= mem[addr[2:0]] & 32'h0000_FFFF;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Load a memory image while the sequencer is idle (called at a negedge).
   task automatic load_mem(input bit randomize);
      for (int i = 0; i < DEPTH; i++) begin
         load_img[i] = randomize ? $urandom : ((32'h1111_0000 * (i + 1)) | i);
      end
      mem_load = 1'b1;
      @(negedge clk);
      mem_load = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = load_img[i];
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) check(tag, mem[i], model_mem[i]);
   endtask

   // Issue one command starting at a negedge; returns at the negedge of the done cycle.
   task automatic do_cmd(input logic [31:0] base, input logic [3:0] count,
                         input bit drop_valid, output int acc_cyc);
      int n;
      int waited;
      int idx;
      logic [31:0] exp_x;
      n = (int'(count) > DEPTH) ? DEPTH : int'(count);
      exp_x = 32'h0;
      for (int k = 0; k < n; k++) exp_x ^= model_mem[(int'(base[2:0]) + k) % DEPTH];
      cmd_base  = base;
      cmd_count = count;
      cmd_valid = 1'b1;
      waited = 0;
      acc_cyc = -1;
      while (!cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (drop_valid) cmd_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         idx = (int'(base[2:0]) + k) % DEPTH;
         check("run_enable", 32'(enable), 32'd1);
         check("run_busy", 32'(busy), 32'd1);
         check("run_addr", addr, 32'(idx));
         check("run_done", 32'(done), 32'd0);
         check("run_ready", 32'(cmd_ready), 32'd0);
         model_mem[idx] = model_mem[idx] & 32'h0000_FFFF;
         @(negedge clk);
      end
      check("done_pulse", 32'(done), 32'd1);
      check("done_enable", 32'(enable), 32'd0);
      check("done_ready", 32'(cmd_ready), 32'd0);
      check("done_xor", xor_out, exp_x);
      exp_last_xor = exp_x;
   endtask

   // Cycle after done: ready again, pulse gone, checksum held.
   task automatic check_after_done();
      @(negedge clk);
      check("post_ready", 32'(cmd_ready), 32'd1);
      check("post_done", 32'(done), 32'd0);
      check("post_xor_hold", xor_out, exp_last_xor);
   endtask

   initial begin
      int a1;
      int a2;
      logic [31:0] rb;
      logic [3:0]  rc;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_base  = 32'h0;
      cmd_count = 4'h0;
      mem_load  = 1'b0;

      // Reset then idle (memory image loaded during reset).
      for (int i = 0; i < DEPTH; i++) load_img[i] = (32'h1111_0000 * (i + 1)) | i;
      mem_load = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      mem_load = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = load_img[i];
      for (int i = 0; i < 4; i++) begin
         check("rst_ready", 32'(cmd_ready), 32'd1);
         check("rst_enable", 32'(enable), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_addr", addr, 32'd0);
         check("rst_xor", xor_out, 32'd0);
         check("rst_done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // Basic sweep: base 2, count 3.
      do_cmd(32'd2, 4'd3, 1'b1, a1);
      check("basic_xor_abs", exp_last_xor,
            32'h3333_0002 ^ 32'h4444_0003 ^ 32'h5555_0004);
      check_after_done();
      check_mem("basic_mem");

      // Wrap and clamp: base 0xE (ptr 6), count 15 -> 8 words.
      do_cmd(32'h0000_000E, 4'd15, 1'b1, a1);
      check_after_done();
      check_mem("wrap_mem");

      // Zero count.
      load_mem(1'b1);
      do_cmd($urandom, 4'd0, 1'b1, a1);
      check("zero_xor", xor_out, 32'd0);
      check_after_done();
      check_mem("zero_mem");

      // Back-to-back with valid held high throughout.
      load_mem(1'b1);
      do_cmd(32'd5, 4'd2, 1'b0, a1);
      do_cmd(32'd1, 4'd1, 1'b1, a2);
      check("b2b_period", 32'(a2 - a1), 32'd4);
      check_after_done();
      check_mem("b2b_mem");

      // Reset on the 3rd enable cycle of a count-6 sweep.
      cmd_base  = 32'd3;
      cmd_count = 4'd6;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_enable_pre", 32'(enable), 32'd1);
      check("mid_addr_pre", addr, 32'd5);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("mid_enable", 32'(enable), 32'd0);
      check("mid_ready", 32'(cmd_ready), 32'd1);
      check("mid_xor", xor_out, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("mid_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // Randomized commands against the arithmetic reference.
      load_mem(1'b1);
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) load_mem(1'b1);
         rb = $urandom;
         rc = 4'($urandom_range(0, 15));
         do_cmd(rb, rc, 1'b1, a1);
         check_after_done();
         check_mem("rand_mem");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
